// File: rtl/cache_types.sv
// Shared types for the L1 cache controller: FSM states, datapath select
// encodings and the way count.
package cache_types;

    localparam int NUM_WAYS = 2;

    typedef enum logic [1:0] {
        CHECK       = 2'd0,
        WRITEBACK   = 2'd1,
        ALLOCATE    = 2'd2,
        REFILL_DONE = 2'd3
    } cache_state_t;

    typedef enum logic {
        DATA_SEL_CPU  = 1'b0,
        DATA_SEL_PMEM = 1'b1
    } data_sel_t;

    typedef enum logic {
        ADDR_CPU    = 1'b0,
        ADDR_VICTIM = 1'b1
    } pmem_addr_sel_t;

    // One-hot per-way strobe for the given way index.
    function automatic logic [NUM_WAYS-1:0] way_onehot(input logic way);
        logic [NUM_WAYS-1:0] r_mask;
        r_mask      = '0;
        r_mask[way] = 1'b1;
        return r_mask;
    endfunction

endpackage

// File: rtl/cache_control_if.sv
// Bundle of CPU port, datapath strobes/status and physical-memory handshake
// seen by the cache controller. master = controller, slave = environment.
interface cache_control_if;
    import cache_types::*;

    // CPU side
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_resp;
    // Datapath status
    logic                 hit0;
    logic                 hit1;
    logic                 valid_v;
    logic                 dirty_v;
    logic                 lru_out;
    // Datapath strobes
    logic [NUM_WAYS-1:0]  load_data;
    logic [NUM_WAYS-1:0]  load_tag;
    logic [NUM_WAYS-1:0]  set_valid;
    logic [NUM_WAYS-1:0]  set_dirty;
    logic [NUM_WAYS-1:0]  clr_dirty;
    logic                 load_lru;
    logic                 lru_in;
    data_sel_t            data_sel;
    pmem_addr_sel_t       pmem_addr_sel;
    // Physical memory
    logic                 pmem_read;
    logic                 pmem_write;
    logic                 pmem_resp;

    modport master (
        input  mem_read, mem_write, hit0, hit1, valid_v, dirty_v, lru_out, pmem_resp,
        output mem_resp, load_data, load_tag, set_valid, set_dirty, clr_dirty,
               load_lru, lru_in, data_sel, pmem_addr_sel, pmem_read, pmem_write
    );

    modport slave (
        output mem_read, mem_write, hit0, hit1, valid_v, dirty_v, lru_out, pmem_resp,
        input  mem_resp, load_data, load_tag, set_valid, set_dirty, clr_dirty,
               load_lru, lru_in, data_sel, pmem_addr_sel, pmem_read, pmem_write
    );

endinterface

// File: rtl/cache_perf_counter.sv
// Free-running event counter, wraps modulo 2^COUNT_W.
module cache_perf_counter #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    logic [COUNT_W-1:0] r_count;

    // Count one per cycle with inc high; reset clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back L1 cache: hit/miss decision,
// datapath strobes, victim write-back and line allocate, hit/miss counters.
module cache_control
    import cache_types::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    cache_control_if.master    bus,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count
);

    cache_state_t       r_state;
    cache_state_t       w_next_state;
    logic               r_victim;
    logic               r_counted;
    logic               w_req;
    logic               w_hit;
    logic               w_hway;
    logic               w_miss_start;
    logic               w_hit_inc;
    logic [COUNT_W-1:0] w_hit_count;
    logic [COUNT_W-1:0] w_miss_count;

    assign w_req  = bus.mem_read | bus.mem_write;
    assign w_hit  = bus.hit0 | bus.hit1;
    assign w_hway = bus.hit1;

    // State register; reset abandons any memory transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CHECK;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Victim way is latched at the miss so later lru_out changes cannot
    // redirect the refill; counted flag keeps the re-check hit out of hit_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_victim  <= 1'b0;
            r_counted <= 1'b0;
        end else if (w_miss_start) begin
            r_victim  <= bus.lru_out;
            r_counted <= 1'b1;
        end else if (bus.mem_resp) begin
            r_counted <= 1'b0;
        end
    end

    // Next-state and strobe decode; everything is held low while in reset.
    always_comb begin
        w_next_state      = r_state;
        w_miss_start      = 1'b0;
        w_hit_inc         = 1'b0;
        bus.mem_resp      = 1'b0;
        bus.load_data     = '0;
        bus.load_tag      = '0;
        bus.set_valid     = '0;
        bus.set_dirty     = '0;
        bus.clr_dirty     = '0;
        bus.load_lru      = 1'b0;
        bus.lru_in        = 1'b0;
        bus.data_sel      = DATA_SEL_CPU;
        bus.pmem_addr_sel = ADDR_CPU;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        if (!rst) begin
            case (r_state)
                CHECK: begin
                    if (w_req) begin
                        if (w_hit) begin
                            bus.mem_resp = 1'b1;
                            bus.load_lru = 1'b1;
                            bus.lru_in   = ~w_hway;
                            // A write wins over a simultaneous read.
                            if (bus.mem_write) begin
                                bus.load_data = way_onehot(w_hway);
                                bus.set_dirty = way_onehot(w_hway);
                                bus.data_sel  = DATA_SEL_CPU;
                            end
                            w_hit_inc = ~r_counted;
                        end else begin
                            w_miss_start = 1'b1;
                            w_next_state = (bus.valid_v & bus.dirty_v) ? WRITEBACK : ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write    = 1'b1;
                    bus.pmem_addr_sel = ADDR_VICTIM;
                    if (bus.pmem_resp) begin
                        bus.clr_dirty = way_onehot(r_victim);
                        w_next_state  = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    bus.pmem_read     = 1'b1;
                    bus.pmem_addr_sel = ADDR_CPU;
                    if (bus.pmem_resp) begin
                        bus.load_data = way_onehot(r_victim);
                        bus.load_tag  = way_onehot(r_victim);
                        bus.set_valid = way_onehot(r_victim);
                        bus.data_sel  = DATA_SEL_PMEM;
                        w_next_state  = REFILL_DONE;
                    end
                end
                REFILL_DONE: begin
                    w_next_state = CHECK;
                end
                default: begin
                    w_next_state = CHECK;
                end
            endcase
        end
    end

    cache_perf_counter #(.COUNT_W(COUNT_W)) u_hit_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hit_inc),
        .count (w_hit_count)
    );

    cache_perf_counter #(.COUNT_W(COUNT_W)) u_miss_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_miss_start),
        .count (w_miss_count)
    );

    assign hit_count  = rst ? '0 : w_hit_count;
    assign miss_count = rst ? '0 : w_miss_count;

endmodule

// File: tb/tb_cache_control.sv
// Testbench for cache_control: directed scenarios plus randomized
// transactions against a transaction-level expectation of the controller.
module tb_cache_control;
    import cache_types::*;

    localparam int COUNT_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [COUNT_W-1:0] hit_count;
    logic [COUNT_W-1:0] miss_count;

    int vectors    = 0;
    int miscompares = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    cache_control_if bus ();

    cache_control #(.COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Flatten all controller outputs into one word.
    function automatic logic [16:0] pack_outs();
        return {bus.mem_resp, bus.load_data, bus.load_tag, bus.set_valid,
                bus.set_dirty, bus.clr_dirty, bus.load_lru, bus.lru_in,
                bus.data_sel, bus.pmem_addr_sel, bus.pmem_read, bus.pmem_write};
    endfunction

    function automatic logic [16:0] ev(input logic resp, input logic [1:0] ld,
                                       input logic [1:0] lt, input logic [1:0] sv,
                                       input logic [1:0] sd, input logic [1:0] cd,
                                       input logic llru, input logic lin,
                                       input logic dsel, input logic asel,
                                       input logic pr, input logic pw);
        return {resp, ld, lt, sv, sd, cd, llru, lin, dsel, asel, pr, pw};
    endfunction

    function automatic logic [1:0] oh(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    // Expected outputs of a completing hit on way hw.
    function automatic logic [16:0] hit_vec(input logic wr, input logic hw);
        return ev(1'b1, wr ? oh(hw) : 2'b00, 2'b00, 2'b00, wr ? oh(hw) : 2'b00,
                  2'b00, 1'b1, ~hw, DATA_SEL_CPU, ADDR_CPU, 1'b0, 1'b0);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic set_in(input logic rd, input logic wr, input logic h0, input logic h1,
                          input logic vv, input logic dv, input logic lru, input logic presp);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.hit0      = h0;
        bus.hit1      = h1;
        bus.valid_v   = vv;
        bus.dirty_v   = dv;
        bus.lru_out   = lru;
        bus.pmem_resp = presp;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        rst = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = pack_outs();
            vectors++;
            if (got !== 17'd0) begin
                miscompares++;
                $display("FAIL reset_outs[%0d]: got %h want 00000", i, got);
            end
            vectors++;
            if (hit_count !== '0 || miss_count !== '0) begin
                miscompares++;
                $display("FAIL reset_counts[%0d]: got %0d/%0d want 0/0", i, hit_count, miss_count);
            end
            step();
        end
        rst = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b0, rb(), rb(), rb(), rb(), rb(), 1'b1);
            @(negedge clk);
            got = pack_outs();
            vectors++;
            if (got !== 17'd0) begin
                miscompares++;
                $display("FAIL idle_outs[%0d]: got %h want 00000", i, got);
            end
            vectors++;
            if (hit_count !== '0 || miss_count !== '0) begin
                miscompares++;
                $display("FAIL idle_counts[%0d]: got %0d/%0d want 0/0", i, hit_count, miss_count);
            end
            step();
        end
    endtask

    task automatic test_read_hit();
        logic [16:0] got;
        logic [16:0] want;
        set_in(1'b1, 1'b0, 1'b0, 1'b1, rb(), rb(), rb(), 1'b0);
        want = ev(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0,
                  DATA_SEL_CPU, ADDR_CPU, 1'b0, 1'b0);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL read_hit: got %h want %h", got, want);
        end
        step();
        exp_hits++;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (hit_count !== COUNT_W'(exp_hits) || miss_count !== COUNT_W'(exp_misses)) begin
            miscompares++;
            $display("FAIL read_hit_count: got %0d/%0d want %0d/%0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
        step();
    endtask

    task automatic test_write_hit();
        logic [16:0] got;
        logic [16:0] want;
        set_in(1'b0, 1'b1, 1'b1, 1'b0, rb(), rb(), rb(), 1'b0);
        want = ev(1'b1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1,
                  DATA_SEL_CPU, ADDR_CPU, 1'b0, 1'b0);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL write_hit_w0: got %h want %h", got, want);
        end
        step();
        exp_hits++;
        // read and write together: the write is the one serviced
        set_in(1'b1, 1'b1, 1'b0, 1'b1, rb(), rb(), rb(), 1'b0);
        want = ev(1'b1, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0,
                  DATA_SEL_CPU, ADDR_CPU, 1'b0, 1'b0);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL write_hit_rw_w1: got %h want %h", got, want);
        end
        step();
        exp_hits++;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (hit_count !== COUNT_W'(exp_hits)) begin
            miscompares++;
            $display("FAIL write_hit_count: got %0d want %0d", hit_count, exp_hits);
        end
        step();
    endtask

    task automatic test_clean_miss();
        logic [16:0] got;
        logic [16:0] want;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== 17'd0) begin
            miscompares++;
            $display("FAIL clean_check: got %h want 00000", got);
        end
        step();
        exp_misses++;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i == 2);
            if (i == 2)
                want = ev(1'b0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0,
                          DATA_SEL_PMEM, ADDR_CPU, 1'b1, 1'b0);
            else
                want = ev(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0,
                          DATA_SEL_CPU, ADDR_CPU, 1'b1, 1'b0);
            @(negedge clk);
            got = pack_outs();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL clean_alloc[%0d]: got %h want %h", i, got, want);
            end
            if (i == 0) begin
                vectors++;
                if (miss_count !== COUNT_W'(exp_misses) || hit_count !== COUNT_W'(exp_hits)) begin
                    miscompares++;
                    $display("FAIL clean_miss_count: got %0d/%0d want %0d/%0d",
                             hit_count, miss_count, exp_hits, exp_misses);
                end
            end
            step();
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== 17'd0) begin
            miscompares++;
            $display("FAIL clean_bubble: got %h want 00000", got);
        end
        step();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        want = hit_vec(1'b0, 1'b1);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL clean_recheck: got %h want %h", got, want);
        end
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (hit_count !== COUNT_W'(exp_hits) || miss_count !== COUNT_W'(exp_misses)) begin
            miscompares++;
            $display("FAIL clean_final_count: got %0d/%0d want %0d/%0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
        step();
    endtask

    task automatic test_dirty_miss();
        logic [16:0] got;
        logic [16:0] want;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== 17'd0) begin
            miscompares++;
            $display("FAIL dirty_check: got %h want 00000", got);
        end
        step();
        exp_misses++;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, i == 1);
            want = ev(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, (i == 1) ? 2'b01 : 2'b00,
                      1'b0, 1'b0, DATA_SEL_CPU, ADDR_VICTIM, 1'b0, 1'b1);
            @(negedge clk);
            got = pack_outs();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL dirty_wb[%0d]: got %h want %h", i, got, want);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, i == 1);
            if (i == 1)
                want = ev(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0,
                          DATA_SEL_PMEM, ADDR_CPU, 1'b1, 1'b0);
            else
                want = ev(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0,
                          DATA_SEL_CPU, ADDR_CPU, 1'b1, 1'b0);
            @(negedge clk);
            got = pack_outs();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL dirty_alloc[%0d]: got %h want %h", i, got, want);
            end
            step();
        end
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== 17'd0) begin
            miscompares++;
            $display("FAIL dirty_bubble: got %h want 00000", got);
        end
        step();
        want = hit_vec(1'b1, 1'b0);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL dirty_recheck: got %h want %h", got, want);
        end
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (hit_count !== COUNT_W'(exp_hits) || miss_count !== COUNT_W'(exp_misses)) begin
            miscompares++;
            $display("FAIL dirty_final_count: got %0d/%0d want %0d/%0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
        step();
    endtask

    task automatic test_reset_mid_alloc();
        logic [16:0] got;
        logic [16:0] want;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        want = ev(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0,
                  DATA_SEL_CPU, ADDR_CPU, 1'b1, 1'b0);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL rmid_alloc1: got %h want %h", got, want);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== 17'd0) begin
            miscompares++;
            $display("FAIL rmid_rst_outs: got %h want 00000", got);
        end
        step();
        rst = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== 17'd0) begin
            miscompares++;
            $display("FAIL rmid_after_outs: got %h want 00000", got);
        end
        vectors++;
        if (hit_count !== '0 || miss_count !== '0) begin
            miscompares++;
            $display("FAIL rmid_counts: got %0d/%0d want 0/0", hit_count, miss_count);
        end
        step();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        want = hit_vec(1'b0, 1'b0);
        @(negedge clk);
        got = pack_outs();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL rmid_later_hit: got %h want %h", got, want);
        end
        step();
        exp_hits++;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vectors++;
        if (hit_count !== COUNT_W'(exp_hits) || miss_count !== '0) begin
            miscompares++;
            $display("FAIL rmid_later_count: got %0d/%0d want %0d/0",
                     hit_count, miss_count, exp_hits);
        end
        step();
    endtask

    task automatic test_random();
        logic [16:0] got;
        logic [16:0] want;
        logic        rd, wr, hw, lru, vv, dv;
        int          nwb, nal, gap;
        for (int t = 0; t < 200; t++) begin
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                set_in(1'b0, 1'b0, rb(), rb(), rb(), rb(), rb(), rb());
                @(negedge clk);
                got = pack_outs();
                vectors++;
                if (got !== 17'd0) begin
                    miscompares++;
                    $display("FAIL rand_idle t=%0d: got %h want 00000", t, got);
                end
                if (g == 0) begin
                    vectors++;
                    if (hit_count !== COUNT_W'(exp_hits) || miss_count !== COUNT_W'(exp_misses)) begin
                        miscompares++;
                        $display("FAIL rand_count t=%0d: got %0d/%0d want %0d/%0d",
                                 t, hit_count, miss_count, exp_hits, exp_misses);
                    end
                end
                step();
            end
            wr = rb();
            rd = wr ? rb() : 1'b1;
            if (rb()) begin
                hw = rb();
                set_in(rd, wr, ~hw, hw, rb(), rb(), rb(), rb());
                want = hit_vec(wr, hw);
                @(negedge clk);
                got = pack_outs();
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL rand_hit t=%0d: got %h want %h", t, got, want);
                end
                step();
                exp_hits++;
            end else begin
                lru = rb();
                vv  = rb();
                dv  = rb();
                nwb = $urandom_range(1, 4);
                nal = $urandom_range(1, 4);
                set_in(rd, wr, 1'b0, 1'b0, vv, dv, lru, rb());
                @(negedge clk);
                got = pack_outs();
                vectors++;
                if (got !== 17'd0) begin
                    miscompares++;
                    $display("FAIL rand_miss_check t=%0d: got %h want 00000", t, got);
                end
                step();
                exp_misses++;
                if (vv && dv) begin
                    for (int i = 0; i < nwb; i++) begin
                        set_in(rd, wr, rb(), rb(), rb(), rb(), rb(), i == nwb - 1);
                        want = ev(1'b0, 2'b00, 2'b00, 2'b00, 2'b00,
                                  (i == nwb - 1) ? oh(lru) : 2'b00, 1'b0, 1'b0,
                                  DATA_SEL_CPU, ADDR_VICTIM, 1'b0, 1'b1);
                        @(negedge clk);
                        got = pack_outs();
                        vectors++;
                        if (got !== want) begin
                            miscompares++;
                            $display("FAIL rand_wb t=%0d c=%0d: got %h want %h", t, i, got, want);
                        end
                        step();
                    end
                end
                for (int i = 0; i < nal; i++) begin
                    set_in(rd, wr, rb(), rb(), rb(), rb(), rb(), i == nal - 1);
                    if (i == nal - 1)
                        want = ev(1'b0, oh(lru), oh(lru), oh(lru), 2'b00, 2'b00, 1'b0, 1'b0,
                                  DATA_SEL_PMEM, ADDR_CPU, 1'b1, 1'b0);
                    else
                        want = ev(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0,
                                  DATA_SEL_CPU, ADDR_CPU, 1'b1, 1'b0);
                    @(negedge clk);
                    got = pack_outs();
                    vectors++;
                    if (got !== want) begin
                        miscompares++;
                        $display("FAIL rand_alloc t=%0d c=%0d: got %h want %h", t, i, got, want);
                    end
                    step();
                end
                set_in(rd, wr, ~lru, lru, rb(), rb(), rb(), rb());
                @(negedge clk);
                got = pack_outs();
                vectors++;
                if (got !== 17'd0) begin
                    miscompares++;
                    $display("FAIL rand_bubble t=%0d: got %h want 00000", t, got);
                end
                step();
                set_in(rd, wr, ~lru, lru, rb(), rb(), rb(), rb());
                want = hit_vec(wr, lru);
                @(negedge clk);
                got = pack_outs();
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL rand_recheck t=%0d: got %h want %h", t, got, want);
                end
                step();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_read_hit();
        test_write_hit();
        test_clean_miss();
        test_dirty_miss();
        test_reset_mid_alloc();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_control.md
# cache_control

Sequencing FSM for the 2-way set-associative, write-back L1 cache: decides hit/miss, drives load/select strobes into the cache datapath (tag/valid/dirty/LRU arrays and the 256-bit line write-merge stage), and runs the write-back and allocate transactions to physical memory. It sits between the CPU memory port and the cache datapath. It owns no data itself. It also keeps hit/miss performance counters.

## Interface
- `COUNT_W`, 32: width of the hit and miss counters.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: CPU read request; held until `mem_resp`.
- `mem_write` in 1: CPU write request; held until `mem_resp`.
- `mem_resp` out 1: request complete, 1-cycle pulse.
- `hit0`, `hit1` in 1 each: datapath tag compare for way 0/1; valid-qualified.
- `valid_v` in 1: victim way (`lru_out`) valid.
- `dirty_v` in 1: victim way dirty.
- `lru_out` in 1: LRU way of the addressed set.
- `load_data` out 2: per-way data array write enable.
- `load_tag` out 2: per-way tag write enable.
- `set_valid` out 2: per-way valid set.
- `set_dirty` out 2: per-way dirty set.
- `clr_dirty` out 2: per-way dirty clear.
- `load_lru` out 1: LRU array write enable.
- `lru_in` out 1: value written to LRU (way to evict next).
- `data_sel` out 1: line-in source; DATA_SEL_CPU = write-merge output, DATA_SEL_PMEM = `pmem_rdata`.
- `pmem_addr_sel` out 1: ADDR_CPU = {cpu tag, index}, ADDR_VICTIM = {victim tag, index}.
- `pmem_read` out 1: line fill request; held until `pmem_resp`.
- `pmem_write` out 1: line write-back request; held until `pmem_resp`.
- `pmem_resp` in 1: physical memory transaction done.
- `hit_count` out COUNT_W: CPU requests that hit on first check.
- `miss_count` out COUNT_W: CPU requests that missed on first check.

## Operation
- States: CHECK (idle/compare), WRITEBACK, ALLOCATE, REFILL_DONE.
- `req = mem_read | mem_write`; `hit = hit0 | hit1`; `hway = hit1`.
- If both `mem_read` and `mem_write` are high, the write is serviced and the read is ignored.
- **CHECK, no req:** all strobes 0; stay.
- **CHECK, req & hit:**
  - `mem_resp=1`, `load_lru=1`, `lru_in=~hway`.
  - On a write, also `load_data[hway]=1`, `set_dirty[hway]=1`, `data_sel=DATA_SEL_CPU`.
  - Stay in CHECK.
  - `hit_count` increments only if the request was not already counted as a miss.
- **CHECK, req & !hit:**
  - `miss_count` increments once.
  - Victim way `v = lru_out`, latched in `victim_q`.
  - Go to WRITEBACK if `valid_v & dirty_v`, else ALLOCATE.
- **WRITEBACK:** `pmem_write=1`, `pmem_addr_sel=ADDR_VICTIM`. On `pmem_resp`: `clr_dirty[victim_q]=1`, go to ALLOCATE.
- **ALLOCATE:** `pmem_read=1`, `pmem_addr_sel=ADDR_CPU`. On `pmem_resp`:
  - `load_data[victim_q]=1`, `load_tag[victim_q]=1`, `set_valid[victim_q]=1`, `data_sel=DATA_SEL_PMEM`.
  - Go to REFILL_DONE.
- **REFILL_DONE:** 1-cycle bubble for array write to settle; strobes 0; go to CHECK. The re-check then hits and completes the request through the hit path, including the write merge.
- `counted_q` flag: set on miss, cleared on `mem_resp`. It suppresses the hit increment on the post-refill re-check.
- Counters wrap modulo 2^COUNT_W.
- `pmem_resp` in CHECK or REFILL_DONE is ignored.

## Timing
- Outputs are combinational from state and inputs. State, `victim_q`, `counted_q` and the counters are registered.
- Read or write hit: `mem_resp` in the same cycle as the request (latency 0 after request visible).
- Clean miss: 1 (CHECK) + N_alloc + 1 (REFILL_DONE) + 1 (CHECK hit) cycles.
- Dirty miss: adds N_wb cycles of WRITEBACK.
- `pmem_read` and `pmem_write` are never high in the same cycle. Each drops in the cycle after `pmem_resp`.
- Reset behaviour:
  - While `rst=1`, all outputs are forced to 0 regardless of state.
  - On the next edge: state=CHECK, `victim_q`=0, `counted_q`=0, `hit_count`=0, `miss_count`=0.
  - Reset during WRITEBACK or ALLOCATE abandons the transaction; `pmem_*` drop immediately.

## Structure
- Package `cache_types` holds:
  - state enum `cache_state_t`;
  - `data_sel_t` (DATA_SEL_CPU, DATA_SEL_PMEM);
  - `pmem_addr_sel_t` (ADDR_CPU, ADDR_VICTIM);
  - `NUM_WAYS`=2.
- Sub-module `cache_perf_counter` (COUNT_W; `clk`, `rst`, `inc`, `count`) is instantiated twice, once for hits and once for misses.

## Test plan
- **Reset then idle:** `rst`=1 for 2 cycles with `mem_read`=1 → all outputs 0. After release with no req → state CHECK, counts 0.
- **Read hit:** `mem_read`=1, `hit1`=1 → same cycle `mem_resp`=1, `load_lru`=1, `lru_in`=0, `load_data`=00; `hit_count` 0→1.
- **Write hit:** `mem_write`=1, `hit0`=1 → `load_data`=01, `set_dirty`=01, `data_sel`=CPU, `lru_in`=1, `mem_resp`=1.
- **Clean miss:** `lru_out`=1, `valid_v`=0, `pmem_resp` after 3 cycles → `pmem_read` 3 cycles, `load_data`=10 with `data_sel`=PMEM, bubble, then hit resp; `miss_count`=1, `hit_count`=0.
- **Dirty miss:** `valid_v`=`dirty_v`=1, `lru_out`=0 → `pmem_write` with ADDR_VICTIM until `pmem_resp`, `clr_dirty`=01, then `pmem_read`; `pmem_read` and `pmem_write` never overlap.
- **Reset mid-ALLOCATE:** `rst` asserted on the 2nd ALLOCATE cycle → `pmem_read`=0 that cycle; CHECK on the next edge; counters 0; a later request is processed normally.
